// File: rtl/dac_pkg.sv
// Shared constants, state encoding and frame builder for the MCP4921 DAC writer.
package dac_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IDX_W   = 4;

  // Frame bit positions of the MCP4921 write command
  localparam int unsigned BIT_AB   = 15;
  localparam int unsigned BIT_BUF  = 14;
  localparam int unsigned BIT_GA   = 13;
  localparam int unsigned BIT_SHDN = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_LDAC  = 3'd5
  } dac_state_t;

  // Build a channel-A write frame with the output enabled
  function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] value,
                                                    input logic buf_en,
                                                    input logic ga_n);
    logic [FRAME_W-1:0] frame;
    frame                = '0;
    frame[BIT_AB]        = 1'b0;
    frame[BIT_BUF]       = buf_en;
    frame[BIT_GA]        = ga_n;
    frame[BIT_SHDN]      = 1'b1;
    frame[DATA_W-1:0]    = value;
    return frame;
  endfunction

endpackage

// File: rtl/dac_spi_tick.sv
// Clearable divider: one-cycle tick every 'div' cycles, restarted by clr.
module dac_spi_tick
  import dac_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             tick_c
);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == (div - CNT_W'(1)));

  // Count up, reload to zero on tick or on a state change
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dac_mcp4921_spi.sv
// Serialises one 16-bit MCP4921 write per LATCH rising edge, then pulses LDAC.
module dac_mcp4921_spi
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned LDAC_LEN = 4,
  parameter bit          BUF      = 1'b0,
  parameter bit          GA_N     = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] VALUE,
  input  logic              LATCH,
  output logic              CS_DAC,
  output logic              CLK_DAC,
  output logic              SDI_DAC,
  output logic              LDAC_DAC,
  output logic              BUSY
);

  dac_state_t         state, state_nxt;
  logic               latch_q;
  logic               pending, pending_nxt;
  logic [DATA_W-1:0]  word_next, word_next_nxt;
  logic [FRAME_W-1:0] sr, sr_nxt;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic               phase, phase_nxt;
  logic               edge_c;
  logic               tick_c;
  logic [CNT_W-1:0]   div_c;
  logic               cs_nxt, sck_nxt, sdi_nxt, ldac_nxt, busy_nxt;

  assign edge_c = LATCH & ~latch_q;
  assign div_c  = (state == ST_LDAC) ? CNT_W'(LDAC_LEN) : CNT_W'(CLK_DIV);

  dac_spi_tick u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (state_nxt != state),
    .div    (div_c),
    .tick_c (tick_c)
  );

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      latch_q   <= 1'b0;
      pending   <= 1'b0;
      word_next <= '0;
      sr        <= '0;
      bit_idx   <= '0;
      phase     <= 1'b0;
    end else begin
      state     <= state_nxt;
      latch_q   <= LATCH;
      pending   <= pending_nxt;
      word_next <= word_next_nxt;
      sr        <= sr_nxt;
      bit_idx   <= bit_idx_nxt;
      phase     <= phase_nxt;
    end
  end

  // Next-state and datapath update; a newer edge always overwrites the queued value
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    word_next_nxt = edge_c ? VALUE : word_next;
    sr_nxt        = sr;
    bit_idx_nxt   = bit_idx;
    phase_nxt     = phase;
    if (edge_c && (state != ST_IDLE)) begin
      pending_nxt = 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (edge_c || pending) begin
          sr_nxt      = make_frame(edge_c ? VALUE : word_next, BUF, GA_N);
          pending_nxt = 1'b0;
          state_nxt   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick_c) begin
          state_nxt   = ST_SHIFT;
          bit_idx_nxt = IDX_W'(FRAME_W - 1);
          phase_nxt   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          if (!phase) begin
            phase_nxt = 1'b1;
          end else if (bit_idx == '0) begin
            phase_nxt = 1'b0;
            state_nxt = ST_HOLD;
          end else begin
            phase_nxt   = 1'b0;
            sr_nxt      = {sr[FRAME_W-2:0], 1'b0};
            bit_idx_nxt = bit_idx - IDX_W'(1);
          end
        end
      end
      ST_HOLD: if (tick_c) state_nxt = ST_GAP;
      ST_GAP:  if (tick_c) state_nxt = ST_LDAC;
      ST_LDAC: if (tick_c) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output levels for the coming cycle, derived from the next state
  always_comb begin
    cs_nxt   = 1'b1;
    sck_nxt  = 1'b0;
    sdi_nxt  = 1'b0;
    ldac_nxt = 1'b1;
    busy_nxt = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_SETUP, ST_HOLD: begin
        cs_nxt  = 1'b0;
        sdi_nxt = sr_nxt[FRAME_W-1];
      end
      ST_SHIFT: begin
        cs_nxt  = 1'b0;
        sck_nxt = phase_nxt;
        sdi_nxt = sr_nxt[FRAME_W-1];
      end
      ST_LDAC: ldac_nxt = 1'b0;
      default: ;
    endcase
  end

  // Registered pin drivers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CS_DAC   <= 1'b1;
      CLK_DAC  <= 1'b0;
      SDI_DAC  <= 1'b0;
      LDAC_DAC <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      CS_DAC   <= cs_nxt;
      CLK_DAC  <= sck_nxt;
      SDI_DAC  <= sdi_nxt;
      LDAC_DAC <= ldac_nxt;
      BUSY     <= busy_nxt;
    end
  end

endmodule
